wb_interconnect: RTL and testbench
==================================

// Module: wb_interconnect
// PURPOSE
//  Single-master Wishbone (classic, 32-bit) slave port decoding to three internal targets:
//  on-chip SRAM, an 8-bit output register (wb2byteout) and an 8-bit GPIO port (wb2byteio).
//  Sits between the SoC CPU bus master and memory/peripherals; returns ack + read data.
// PARAMETERS
//  SRAM_ADR_BASE        32'h0000_0000  SRAM window base; window = 128 KiB (0x0000_0000..0x0001_FFFF)
//  WB2BYTEOUT_ADR_BASE  32'h0002_0300  wb2byteout window base, 128 B
//  WB2BYTEIO_ADR_BASE   32'h0002_0380  wb2byteio window base, 128 B
// PORTS
//  i_clk              in   1   clock, all logic on rising edge
//  i_rst_n            in   1   reset, asynchronous, active-low
//  i_wbm_stb          in   1   request strobe
//  i_wbm_cyc          in   1   bus cycle; ignored (request = i_wbm_stb alone)
//  i_wbm_we           in   1   1=write, 0=read
//  i_wbm_sel          in   4   byte enables, sel[n] -> dat[8n+7:8n]
//  i_wbm_adr          in   32  byte address; adr[1:0] ignored (word access)
//  i_wbm_dat          in   32  write data
//  o_wbs_ack          out  1   one-cycle acknowledge
//  o_wbs_dat          out  32  read data, registered
//  wb2byteio_o_iobuf  out  8   GPIO pad value driven by wb2byteio
// BEHAVIOUR
//  - Reset: o_wbs_ack=0, o_wbs_dat=0, all peripheral registers 0; SRAM contents not reset.
//  - Handshake: ack <= stb & ~ack. stb rises at edge N -> ack=1 after edge N+1 -> ack=0 after N+2
//    even if stb still high. Access (write or read capture) happens on the edge that sets ack.
//  - Read: o_wbs_dat loaded on the ack-setting edge; held unchanged until the next read ack.
//  - Write: only bytes with sel=1 updated; 8-bit registers use sel[0]/dat[7:0] only.
//  - Decode: SRAM if adr in [base, base+0x1FFFF]; byteout/byteio if adr[31:7] matches base.
//    Unmapped: still acked, write dropped, read returns 0 (bus never hangs).
//  - SRAM: 32K x 32 words, index adr[16:2]; unwritten locations read X/undefined.
//  - wb2byteout: +0 OUT reg [7:0], R/W, reads zero-extended; other offsets read 0.
//  - wb2byteio offsets: +0 IN (RO) = wb2byteio_o_iobuf; +4 S data reg (RW);
//    +8 C direction reg (RW, bit=1 input, 0 output); +12 CFG (RW, 8-bit):
//    writing CFG also loads C[3:0]={4{dat[0]}}, C[7:4]={4{dat[4]}}; writing +8 leaves CFG.
//  - iobuf[i] = C[i] ? 1'b0 : S[i] (input pins have no external driver; read as 0).
//  - Reset mid-transfer: ack and data return to 0 immediately; write not performed.
// STRUCTURE
//  - Shared package: address base/mask constants, byteio register offsets (IN/S/C/CFG).
//  - Top: decoder, ack register, read mux/data register, SRAM array, byteout register.
//  - One sub-module natural: wb2byteio (S/C/CFG regs, iobuf logic, register read).
// TESTING
//  - Write 0x0/0x4/0x8/0x10000 with ABCD_0000/0004/0008/FFFF sel=1111; read back same values;
//    each access: ack 0 at request edge, 1 next edge, 0 the edge after.
//  - Write FFFF_FFFF sel=1001 @0x0 -> read FFCD_00FF; sel=0110 @0x4 -> read ABFF_FF04.
//  - Write 0000_FFAB @0x20300 -> read 0000_00AB.
//  - byteio: C(+8)=0, S(+4)=AB -> read +8=0, +4=AB, +0=AB, iobuf=AB.
//  - CFG(+12)=0x11 -> read +12=0x11, +0=00, iobuf=00; CFG=0x10 -> read +0=0x0B, iobuf=0B.
//  - Unmapped 0x0003_0000 read -> ack pulse, dat=0; reset asserted mid-access -> ack drops to 0.

Source files
------------

// File: rtl/wb_interconnect_pkg.sv
// Shared constants for the Wishbone interconnect: address windows, target selector
// and register word offsets inside the wb2byteio window.
package wb_interconnect_pkg;

    localparam logic [31:0] DEF_SRAM_ADR_BASE       = 32'h0000_0000;
    localparam logic [31:0] DEF_WB2BYTEOUT_ADR_BASE = 32'h0002_0300;
    localparam logic [31:0] DEF_WB2BYTEIO_ADR_BASE  = 32'h0002_0380;

    localparam logic [31:0] SRAM_SPAN  = 32'h0002_0000;
    localparam int          SRAM_AW    = 15;
    localparam int          SRAM_WORDS = 1 << SRAM_AW;

    // Word offsets (adr[6:2]) inside the 128-byte peripheral windows
    localparam logic [4:0] OUT_OFS_OUT   = 5'd0;
    localparam logic [4:0] BYTEIO_OFS_IN  = 5'd0;
    localparam logic [4:0] BYTEIO_OFS_S   = 5'd1;
    localparam logic [4:0] BYTEIO_OFS_C   = 5'd2;
    localparam logic [4:0] BYTEIO_OFS_CFG = 5'd3;

    typedef enum logic [1:0] {
        TGT_NONE,
        TGT_SRAM,
        TGT_BYTEOUT,
        TGT_BYTEIO
    } target_e;

endpackage

// File: rtl/wb_interconnect_wb2byteio.sv
// 8-bit GPIO peripheral: data (S), direction (C) and config (CFG) registers, pad value
// and register read-back. Pins with C=1 are inputs with no external driver and read 0.
module wb_interconnect_wb2byteio
    import wb_interconnect_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr,
    input  logic [4:0] reg_idx,
    input  logic [7:0] wdat,
    output logic [7:0] rdat,
    output logic [7:0] iobuf
);

    logic [7:0] s_reg;
    logic [7:0] c_reg;
    logic [7:0] cfg_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg   <= '0;
            c_reg   <= '0;
            cfg_reg <= '0;
        end else if (wr) begin
            case (reg_idx)
                BYTEIO_OFS_S:   s_reg <= wdat;
                BYTEIO_OFS_C:   c_reg <= wdat;
                BYTEIO_OFS_CFG: begin
                    // CFG bit 0 sets the direction of the low nibble, bit 4 the high nibble
                    cfg_reg <= wdat;
                    c_reg   <= {{4{wdat[4]}}, {4{wdat[0]}}};
                end
                default: ;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pad
            assign iobuf[gi] = c_reg[gi] ? 1'b0 : s_reg[gi];
        end
    endgenerate

    always_comb begin
        rdat = '0;
        case (reg_idx)
            BYTEIO_OFS_IN:  rdat = iobuf;
            BYTEIO_OFS_S:   rdat = s_reg;
            BYTEIO_OFS_C:   rdat = c_reg;
            BYTEIO_OFS_CFG: rdat = cfg_reg;
            default:        rdat = '0;
        endcase
    end

endmodule

// File: rtl/wb_interconnect.sv
// Single-master classic Wishbone slave decoding to SRAM, an 8-bit output register and
// an 8-bit GPIO block. Every request is acked exactly once; unmapped accesses read 0.
module wb_interconnect
    import wb_interconnect_pkg::*;
#(
    parameter logic [31:0] SRAM_ADR_BASE       = DEF_SRAM_ADR_BASE,
    parameter logic [31:0] WB2BYTEOUT_ADR_BASE = DEF_WB2BYTEOUT_ADR_BASE,
    parameter logic [31:0] WB2BYTEIO_ADR_BASE  = DEF_WB2BYTEIO_ADR_BASE
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wbm_stb,
    input  logic        i_wbm_cyc,
    input  logic        i_wbm_we,
    input  logic [3:0]  i_wbm_sel,
    input  logic [31:0] i_wbm_adr,
    input  logic [31:0] i_wbm_dat,
    output logic        o_wbs_ack,
    output logic [31:0] o_wbs_dat,
    output logic [7:0]  wb2byteio_o_iobuf
);

    target_e          target;
    logic             access;
    logic             wr_access;
    logic             rd_access;
    logic             ack_reg;
    logic [SRAM_AW-1:0] sram_idx;
    logic [31:0]      sram_mem [SRAM_WORDS];
    logic [31:0]      sram_rd_reg;
    logic             sram_sel_reg;
    logic [31:0]      periph_rd_reg;
    logic [31:0]      periph_rdata;
    logic [7:0]       out_reg;
    logic [7:0]       byteio_rdat;
    logic             unused_cyc;

    assign unused_cyc = i_wbm_cyc;

    // Gating with reset keeps a request held through reset from touching the SRAM
    assign access    = i_wbm_stb & ~ack_reg & i_rst_n;
    assign wr_access = access & i_wbm_we;
    assign rd_access = access & ~i_wbm_we;
    assign sram_idx  = i_wbm_adr[SRAM_AW+1:2];

    always_comb begin
        target = TGT_NONE;
        if ((i_wbm_adr - SRAM_ADR_BASE) < SRAM_SPAN)
            target = TGT_SRAM;
        else if (i_wbm_adr[31:7] == WB2BYTEOUT_ADR_BASE[31:7])
            target = TGT_BYTEOUT;
        else if (i_wbm_adr[31:7] == WB2BYTEIO_ADR_BASE[31:7])
            target = TGT_BYTEIO;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ack_reg <= 1'b0;
        end else begin
            ack_reg <= access;
        end
    end

    // SRAM kept free of reset so it maps onto block RAM with a registered read port
    always_ff @(posedge i_clk) begin
        if (wr_access && target == TGT_SRAM) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wbm_sel[b])
                    sram_mem[sram_idx][8*b +: 8] <= i_wbm_dat[8*b +: 8];
            end
        end
        if (rd_access && target == TGT_SRAM)
            sram_rd_reg <= sram_mem[sram_idx];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_reg <= '0;
        end else if (wr_access && target == TGT_BYTEOUT && i_wbm_sel[0]
                     && i_wbm_adr[6:2] == OUT_OFS_OUT) begin
            out_reg <= i_wbm_dat[7:0];
        end
    end

    wb_interconnect_wb2byteio u_byteio (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .wr      (wr_access && target == TGT_BYTEIO && i_wbm_sel[0]),
        .reg_idx (i_wbm_adr[6:2]),
        .wdat    (i_wbm_dat[7:0]),
        .rdat    (byteio_rdat),
        .iobuf   (wb2byteio_o_iobuf)
    );

    always_comb begin
        periph_rdata = '0;
        case (target)
            TGT_BYTEOUT: if (i_wbm_adr[6:2] == OUT_OFS_OUT) periph_rdata = {24'd0, out_reg};
            TGT_BYTEIO:  periph_rdata = {24'd0, byteio_rdat};
            default:     periph_rdata = '0;
        endcase
    end

    // Read data selects between the SRAM output register and the peripheral register;
    // reset forces the peripheral path, whose register resets to zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sram_sel_reg  <= 1'b0;
            periph_rd_reg <= '0;
        end else if (rd_access) begin
            sram_sel_reg  <= (target == TGT_SRAM);
            periph_rd_reg <= periph_rdata;
        end
    end

    assign o_wbs_ack = ack_reg;
    assign o_wbs_dat = sram_sel_reg ? sram_rd_reg : periph_rd_reg;

endmodule

// File: tb/tb_wb_interconnect.sv
// Directed bench for wb_interconnect: a transaction-level model predicts ack, read data
// and pad value every cycle, and literal expectations pin the key results.
module tb_wb_interconnect;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0;
    logic [31:0] wdat = 32'h0;
    logic        ack;
    logic [31:0] rdat;
    logic [7:0]  iobuf;

    int total = 0;
    int bad = 0;

    wb_interconnect dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_wbm_stb         (stb),
        .i_wbm_cyc         (cyc),
        .i_wbm_we          (we),
        .i_wbm_sel         (sel),
        .i_wbm_adr         (adr),
        .i_wbm_dat         (wdat),
        .o_wbs_ack         (ack),
        .o_wbs_dat         (rdat),
        .wb2byteio_o_iobuf (iobuf)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic        m_ack;
    logic [31:0] m_dat;
    logic [7:0]  m_out, m_s, m_c, m_cfg;
    logic [31:0] m_sram [int];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic model_access();
        logic [31:0] a;
        logic [31:0] old;
        int k;
        a = {adr[31:2], 2'b00};
        if (a < 32'h0002_0000) begin
            k = int'(a[16:2]);
            old = m_sram.exists(k) ? m_sram[k] : 32'hxxxx_xxxx;
            if (we) m_sram[k] = merge(old, wdat, sel);
            else    m_dat = old;
        end else if (a >= 32'h0002_0300 && a < 32'h0002_0380) begin
            if (we) begin
                if (a == 32'h0002_0300 && sel[0]) m_out = wdat[7:0];
            end else begin
                m_dat = (a == 32'h0002_0300) ? {24'h0, m_out} : 32'h0;
            end
        end else if (a >= 32'h0002_0380 && a < 32'h0002_0400) begin
            if (we) begin
                if (sel[0]) begin
                    if (a == 32'h0002_0384) m_s = wdat[7:0];
                    if (a == 32'h0002_0388) m_c = wdat[7:0];
                    if (a == 32'h0002_038C) begin
                        m_cfg = wdat[7:0];
                        m_c = {{4{wdat[4]}}, {4{wdat[0]}}};
                    end
                end
            end else begin
                case (a)
                    32'h0002_0380: m_dat = {24'h0, m_s & ~m_c};
                    32'h0002_0384: m_dat = {24'h0, m_s};
                    32'h0002_0388: m_dat = {24'h0, m_c};
                    32'h0002_038C: m_dat = {24'h0, m_cfg};
                    default:       m_dat = 32'h0;
                endcase
            end
        end else if (!we) begin
            m_dat = 32'h0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ack = 1'b0; m_dat = 32'h0;
            m_out = 8'h0; m_s = 8'h0; m_c = 8'h0; m_cfg = 8'h0;
        end else if (stb && !m_ack) begin
            model_access();
            m_ack = 1'b1;
        end else begin
            m_ack = 1'b0;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if (ack !== m_ack) begin
                bad++;
                $display("FAIL cyc_ack: got %b want %b at %0t", ack, m_ack, $time);
            end
            if (!$isunknown(m_dat)) begin
                total++;
                if (rdat !== m_dat) begin
                    bad++;
                    $display("FAIL cyc_dat: got %h want %h at %0t", rdat, m_dat, $time);
                end
            end
            total++;
            if (iobuf !== (m_s & ~m_c)) begin
                bad++;
                $display("FAIL cyc_iobuf: got %h want %h at %0t", iobuf, m_s & ~m_c, $time);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic xfer(input logic w, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] r);
        int n;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; sel = s; adr = a; wdat = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack !== 1'b1 && n < 4);
        check($sformatf("%s_lat@%h", w ? "wr" : "rd", a), n, 1);
        r = rdat;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        xfer(1'b1, s, a, d, r);
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        xfer(1'b0, 4'hF, a, 32'h0, r);
        check($sformatf("rd@%h", a), r, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_ack", {31'h0, ack}, 32'h0);
        check("reset_dat", rdat, 32'h0);
        check("reset_iobuf", {24'h0, iobuf}, 32'h0);
        rst_n = 1'b1;

        wr(32'h0000_0000, 32'hABCD_0000, 4'hF);
        wr(32'h0000_0004, 32'hABCD_0004, 4'hF);
        wr(32'h0000_0008, 32'hABCD_0008, 4'hF);
        wr(32'h0001_0000, 32'hABCD_FFFF, 4'hF);
        rd_chk(32'h0000_0000, 32'hABCD_0000);
        rd_chk(32'h0000_0004, 32'hABCD_0004);
        rd_chk(32'h0000_0008, 32'hABCD_0008);
        rd_chk(32'h0001_0000, 32'hABCD_FFFF);

        wr(32'h0000_0000, 32'hFFFF_FFFF, 4'b1001);
        rd_chk(32'h0000_0000, 32'hFFCD_00FF);
        wr(32'h0000_0004, 32'hFFFF_FFFF, 4'b0110);
        rd_chk(32'h0000_0004, 32'hABFF_FF04);

        // stb held high: ack must pulse, drop, then pulse again for the next request
        @(negedge clk);
        stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h0000_0004;
        @(negedge clk); check("held_ack1", {31'h0, ack}, 32'h1);
        @(negedge clk); check("held_ack0", {31'h0, ack}, 32'h0);
        @(negedge clk); check("held_ack2", {31'h0, ack}, 32'h1);
        check("held_dat", rdat, 32'hABFF_FF04);
        stb = 1'b0;

        wr(32'h0002_0300, 32'h0000_FFAB, 4'hF);
        rd_chk(32'h0002_0300, 32'h0000_00AB);
        wr(32'h0002_0300, 32'h0000_00CC, 4'b1110);
        rd_chk(32'h0002_0300, 32'h0000_00AB);
        rd_chk(32'h0002_0304, 32'h0000_0000);

        wr(32'h0002_0388, 32'h0000_0000, 4'hF);
        wr(32'h0002_0384, 32'h0000_00AB, 4'hF);
        rd_chk(32'h0002_0388, 32'h0000_0000);
        rd_chk(32'h0002_0384, 32'h0000_00AB);
        rd_chk(32'h0002_0380, 32'h0000_00AB);
        check("iobuf_ab", {24'h0, iobuf}, 32'h0000_00AB);

        wr(32'h0002_038C, 32'h0000_0011, 4'hF);
        rd_chk(32'h0002_038C, 32'h0000_0011);
        rd_chk(32'h0002_0380, 32'h0000_0000);
        check("iobuf_cfg11", {24'h0, iobuf}, 32'h0000_0000);
        rd_chk(32'h0002_0388, 32'h0000_00FF);
        wr(32'h0002_038C, 32'h0000_0010, 4'hF);
        rd_chk(32'h0002_0380, 32'h0000_000B);
        check("iobuf_cfg10", {24'h0, iobuf}, 32'h0000_000B);
        rd_chk(32'h0002_0388, 32'h0000_00F0);
        wr(32'h0002_0388, 32'h0000_0000, 4'hF);
        rd_chk(32'h0002_038C, 32'h0000_0010);

        wr(32'h0003_0000, 32'hDEAD_BEEF, 4'hF);
        rd_chk(32'h0003_0000, 32'h0000_0000);

        // reset asserted before the ack edge: the write must not land
        wr(32'h0000_0100, 32'h1111_1111, 4'hF);
        rd_chk(32'h0000_0100, 32'h1111_1111);
        @(negedge clk);
        stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h0000_0100; wdat = 32'h2222_2222;
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_pre_ack", {31'h0, ack}, 32'h0);
        check("rst_pre_dat", rdat, 32'h0);
        stb = 1'b0; we = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // reset asserted while ack is high: ack and data clear at once
        @(negedge clk);
        stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h0000_0100;
        @(posedge clk); #1;
        check("rst_mid_ack1", {31'h0, ack}, 32'h1);
        check("rst_mid_dat1", rdat, 32'h1111_1111);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_ack0", {31'h0, ack}, 32'h0);
        check("rst_mid_dat0", rdat, 32'h0);
        stb = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        rd_chk(32'h0000_0100, 32'h1111_1111);
        rd_chk(32'h0002_0384, 32'h0000_0000);
        rd_chk(32'h0002_0300, 32'h0000_0000);
        check("iobuf_after_rst", {24'h0, iobuf}, 32'h0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
